// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the sensor hub UART receiver and transmitter.
//   OVERSAMPLE  : ticks per bit period (16x oversampling)
//   SAMPLE_MID  : sample count at which the 3-sample majority is resolved
//   rx_state_e  : receiver FSM state encoding
//   baud_div()  : rounded clock divisor producing the 16x oversample tick
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned SAMPLE_MID = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

    // Divisor rounded to nearest: (clk_hz + 8*baud) / (16*baud).
    // Clamped to 1 so a very fast baud still yields a usable counter.
    function automatic int unsigned baud_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        int unsigned d;
        d = (clk_hz + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
        if (d == 0) begin
            d = 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Output side of the UART receiver: one-entry holding register with a
// valid/ready handshake plus single-cycle error pulses.
//   data        : received byte, stable while valid is high
//   valid       : a byte is held in data
//   ready       : consumer accepts; transfer on valid && ready
//   frame_err   : pulse, stop bit sampled low
//   overrun     : pulse, byte completed while the holding register was full
//   parity_err  : pulse, even-parity mismatch (0 unless UART_RX_PARITY_EN)
// Modports: master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
interface uart_rx_if;

    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    modport master (
        output data,
        output valid,
        output frame_err,
        output overrun,
        output parity_err,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  frame_err,
        input  overrun,
        input  parity_err,
        output ready
    );

endinterface

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Free-running divisor counter producing a one-cycle tick every DIV clocks
// (the 16x oversample strobe). A synchronous restart reloads the count to 0
// so the receiver can align sampling to a detected start edge.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   restart  : reload counter to 0 this cycle
//   tick     : high for one cycle when the counter reaches DIV-1
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int unsigned DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Asynchronous serial receiver, 8N1 (8E1 with UART_RX_PARITY_EN), LSB first.
// The rx pin is synchronised, sampled at 16x baud and each bit is resolved by
// a 3-sample majority vote around mid-bit. Completed bytes land in a
// one-entry holding register with a valid/ready handshake.
// Parameters:
//   CLK_HZ  : system clock frequency in Hz
//   BAUD    : line rate in bits per second
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   rx      : serial line, idle high, asynchronous to clk
//   bus     : uart_rx_if.master (data/valid/ready and error pulses)
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after data).
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx,
    uart_rx_if.master bus
);

    localparam int unsigned DIV = baud_div(CLK_HZ, BAUD);
    // The majority is resolved on the tick that advances the count to
    // SAMPLE_MID, i.e. while the registered count still reads SAMPLE_MID-1.
    localparam logic [3:0] MID_PRE = 4'(SAMPLE_MID - 1);

    // Synchroniser and edge-detect history; idle-high reset values.
    logic rx_meta_q, rx_meta_d;
    logic rx_sync_q, rx_sync_d;
    logic rx_prev_q, rx_prev_d;

    rx_state_e  state_q, state_d;
    logic [3:0] sample_cnt_q, sample_cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    // samples_q[1] = count-7 sample, samples_q[0] = count-8 sample;
    // the count-9 sample is rx_sync_q itself at the resolving tick.
    logic [1:0] samples_q, samples_d;
    logic [7:0] shift_q, shift_d;

    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;

`ifdef UART_RX_PARITY_EN
    logic       parity_bad_q, parity_bad_d;
    logic       parity_err_q, parity_err_d;
`endif

    logic tick;
    logic baud_restart;
    logic fall_edge;
    logic mid_tick;
    logic majority;
    logic byte_done;

    assign fall_edge    = rx_prev_q & ~rx_sync_q;
    assign baud_restart = (state_q == ST_IDLE) && fall_edge;
    assign mid_tick     = tick && (state_q != ST_IDLE) && (sample_cnt_q == MID_PRE);
    assign majority     = (samples_q[1] & samples_q[0]) |
                          (samples_q[1] & rx_sync_q)    |
                          (samples_q[0] & rx_sync_q);

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (baud_restart),
        .tick    (tick)
    );

    // Next-state, datapath and holding register.
    always_comb begin
        rx_meta_d    = rx;
        rx_sync_d    = rx_meta_q;
        rx_prev_d    = rx_sync_q;

        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_idx_d    = bit_idx_q;
        samples_d    = samples_q;
        shift_d      = shift_q;

        data_d       = data_q;
        valid_d      = valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        byte_done    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_d = parity_bad_q;
        parity_err_d = 1'b0;
`endif

        // Sample counter phases itself to the start edge, then wraps 15 -> 0
        // naturally so every later bit is resolved 16 ticks after the last.
        if (baud_restart) begin
            sample_cnt_d = '0;
        end else if (tick && (state_q != ST_IDLE)) begin
            sample_cnt_d = sample_cnt_q + 4'd1;
        end

        if (tick) begin
            samples_d = {samples_q[0], rx_sync_q};
        end

        case (state_q)
            ST_IDLE: begin
                if (fall_edge) begin
                    state_d   = ST_START;
                    bit_idx_d = '0;
                end
            end

            ST_START: begin
                if (mid_tick) begin
                    if (!majority) begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        parity_bad_d = 1'b0;
`endif
                    end else begin
                        // Too short to be a start bit: silently re-arm.
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_DATA: begin
                if (mid_tick) begin
                    shift_d   = {majority, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (mid_tick) begin
                    // Even parity: the parity bit equals the XOR of the data.
                    parity_bad_d = majority ^ (^shift_q);
                    state_d      = ST_STOP;
                end
            end
`endif

            ST_STOP: begin
                if (mid_tick) begin
`ifdef UART_RX_PARITY_EN
                    parity_err_d = parity_bad_q;
`endif
                    if (majority) begin
                        byte_done = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end

            ST_BREAK: begin
                // Hold off until the line is released so a long break
                // reports only one framing error.
                if (rx_sync_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Holding register: a completion coinciding with a handshake reloads
        // in place; a completion against a stalled full register is dropped.
        if (byte_done) begin
            if (!valid_q || bus.ready) begin
                data_d  = shift_d;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && bus.ready) begin
            valid_d = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            sample_cnt_q <= '0;
            bit_idx_q    <= '0;
            samples_q    <= '0;
            shift_q      <= '0;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_sync_q    <= rx_sync_d;
            rx_prev_q    <= rx_prev_d;
            sample_cnt_q <= sample_cnt_d;
            bit_idx_q    <= bit_idx_d;
            samples_q    <= samples_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            parity_bad_q <= parity_bad_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, 8N1 framing, LSB first. It is the receive counterpart of the sensor hub's `uart_tx` and takes host commands and configuration bytes into the hub. The block synchronises the `rx` pin and samples it at 16× baud with a 3-sample majority vote. Each completed byte goes into a one-entry holding register with a valid/ready output handshake. Framing, overrun and (optionally) parity errors are flagged.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 115200: line rate in bits per second.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `rx`  input  1  serial line (idle high), asynchronous to `clk`.
- `data`  output  8  received byte; stable while `valid` is high.
- `valid`  output  1  a byte is held in `data`.
- `ready`  input  1  consumer accepts; the transfer happens on a cycle where `valid && ready`.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low.
- `overrun`  output  1  one-cycle pulse: a byte completed while the holding register was full.
- `parity_err`  output  1  one-cycle pulse; tied 0 unless `UART_RX_PARITY_EN` is defined.

## Operation
- **Synchroniser:** `rx` passes through a 2-flop synchroniser. Both flops reset to 1.
- **Tick generator:**
  - Divisor DIV = (CLK_HZ + 8·BAUD) / (16·BAUD), integer arithmetic, rounded to nearest. With the defaults, DIV = 27.
  - The counter is sized $clog2(DIV). It produces a 1-cycle `tick` every DIV clocks.
  - It free-runs, and is reloaded to 0 when a falling edge is detected in IDLE.
- **Sample counter:** 4 bits, 0..15 per bit period. At count 9 the bit value is the majority of the samples taken at counts 7, 8 and 9.
- **FSM states:** IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
  - IDLE → START on a synchronised 1→0 transition.
  - START: at the majority point, a 0 goes to DATA with bit index 0. A 1 is treated as a glitch and returns to IDLE with no flag.
  - DATA: at each majority point the bit is shifted into the shift register, LSB first. After index 7, go to PARITY or STOP.
  - STOP, majority 1: the byte is complete; go to IDLE.
  - STOP, majority 0: pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for the synchronised `rx` to read 1, then go to IDLE. This means a held-low line produces exactly one `frame_err`.
- **Holding register:**
  - On byte completion with `valid` low: load `data` and set `valid`.
  - On completion while `valid && !ready`: keep the old data, drop the new byte, pulse `overrun`.
  - On completion in the same cycle as a handshake (`valid && ready`): load the new byte and keep `valid` high. No overrun.
  - A handshake with no completion clears `valid`.
- **Reset values:** `data` = 8'h00; `valid`, `frame_err`, `overrun` and `parity_err` = 0; FSM = IDLE; all counters = 0.
- **Reset mid-frame:** the partial byte is lost. After release the receiver re-arms only on a fresh falling edge.

## Timing
- One bit period is 16·DIV clocks (432 with the defaults).
- **Latency:** `valid` rises 1 cycle after the stop-bit majority tick. That is about 2 (synchroniser) + 9.5625 bit periods after the falling edge on `rx`.
- The error pulses are registered and coincide with the cycle `valid` would have risen.
- **Back-to-back frames:** the FSM returns to IDLE at mid-stop, so a start bit that immediately follows the stop bit is caught.
- **Baud tolerance:** the design tolerates ±3% baud mismatch.

## Configuration
- **Macro:** `UART_RX_PARITY_EN`.
- **Defined:** a PARITY state follows DATA and samples an even-parity bit (frame 8E1).
  - On a mismatch, `parity_err` pulses, but the byte is still delivered (or causes overrun) as normal.
  - The stop check follows the parity bit.
  - Latency grows by one bit period.
- **Undefined:** the frame is 8N1, the PARITY state and its logic are absent, and `parity_err` = 0.

## Structure
- **Package `uart_pkg`:**
  - the FSM state enum;
  - `OVERSAMPLE` = 16;
  - `SAMPLE_MID` = 9;
  - a `baud_div(clk_hz, baud)` constant function.
  - `uart_tx` also uses `uart_pkg`.
- **Sub-module `uart_baud_tick`:** the divisor counter with synchronous restart. It is shareable with the transmitter.

## Test plan
- **Single byte:** send 0xA5 at 115200 baud with `ready` = 1 → one `valid` cycle with `data` = 0xA5, no error pulses.
- **Back-to-back:** send 0x00, 0xFF, 0x3C back-to-back with `ready` held 0 until all three have ended → `data` = 0x00 with `valid` high, `overrun` pulses twice, and a subsequent handshake clears `valid`.
- **Glitch rejection:** a low glitch of 5·DIV clocks on idle `rx` → no `valid` and no `frame_err`; FSM back in IDLE. A following 0x55 is received correctly.
- **Bad stop and break:** send 0x81 with the stop bit forced low, then hold `rx` low for 3 bit periods → exactly one `frame_err` and no `valid`. After `rx` returns high, 0x42 is received.
- **Reset mid-frame:** assert `rst_n` low during data bit 4 of 0xF0 → all outputs 0 immediately. After release, 0x0F is received cleanly.
- **Parity (`UART_RX_PARITY_EN` only):** send 0x07 with parity bit 0 → `parity_err` pulses and `data` = 0x07 with `valid`. Send it with parity bit 1 → no error.
